// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder slice, LSB first, start/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             sub_r;
  logic             sum_bit;
  logic             c_next;
  logic             last;
  logic             load;
  always_comb begin
    sum_bit = ra[0] ^ rb[0] ^ c;
    c_next  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    last    = cnt == CW'(WIDTH - 1);
    load    = start && (state == IDLE || state == DONE);
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  // ra doubles as the result shadow: operand bits leave at the LSB while sum bits enter at the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sub_r <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      state <= RUN;
      ra    <= a;
      rb    <= b ^ {WIDTH{sub}};
      sub_r <= sub;
      c     <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra  <= {sum_bit, ra[WIDTH-1:1]};
      rb  <= rb >> 1;
      c   <= c_next;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        state <= DONE;
        s     <= {sum_bit, ra[WIDTH-1:1]};
        cout  <= c_next ^ sub_r;
        ovf   <= c ^ c_next;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench; driver pushes expected results, negedge monitor pops on done.
module tb_serial_addsub;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         k;
  } exp_t;
  exp_t q[$];

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic m, input logic ci);
    logic [8:0] full;
    int r;
    logic [7:0] rs;
    logic co, ov;
    if (!m) begin
      full = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      rs = full[7:0];
      co = full[8];
      ov = (x[7] == y[7]) && (rs[7] != x[7]);
    end else begin
      rs = x - y - {7'd0, ci};
      co = int'(x) < int'(y) + int'(ci);
      r = int'($signed(x)) - int'($signed(y)) - int'(ci);
      ov = r > 127 || r < -128;
    end
    return {ov, co, rs};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("s", 32'(s), 32'(e.s));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency", 32'(cyc - e.k), 32'd8);
        check("busy_done_overlap", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic m, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
    a = x; b = y; sub = m; cin = ci; start = 1'b1;
    q.push_back('{es, ec, eo, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sub, cin;
    logic [7:0] s;
    logic       cout, ovf;
  } vec_t;
  vec_t vecs[11] = '{
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0},
    '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h03, 8'h03, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0},
    '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1}
  };

  initial begin
    int k1;
    logic [9:0] m;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_s", 32'(s), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf);
    // start held through RUN with changing operands; second op latches at the DONE-exit edge
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    k1 = cyc + 1;
    q.push_back('{8'h46, 1'b0, 1'b0, k1});
    @(negedge clk);
    a = 8'h50; b = 8'h60; sub = 1'b1;
    q.push_back('{8'hF0, 1'b1, 1'b0, k1 + 9});
    wait_done();
    @(negedge clk);
    start = 1'b0;
    check("hold_busy", 32'(busy), 1);
    check("hold_s_early", 32'(s), 32'h46);
    repeat (3) @(negedge clk);
    check("hold_s_late", 32'(s), 32'h46);
    wait_done();
    @(negedge clk);
    a = 8'hAA; b = 8'h11; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_s", 32'(s), 0);
    check("abort_cout", 32'(cout), 0);
    check("abort_ovf", 32'(ovf), 0);
    repeat (10) @(negedge clk);
    check("abort_no_done_s", 32'(s), 0);
    issue(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [7:0] x, y;
      logic md, ci;
      x = 8'($urandom);
      y = 8'($urandom);
      md = 1'($urandom);
      ci = 1'($urandom);
      m = model(x, y, md, ci);
      issue(x, y, md, ci, m[7:0], m[8], m[9]);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
